// File: rtl/pdm_playback_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : pdm_playback_deserializer
// Brief   : Fetches memory words and shifts them MSB-first onto the audio pin,
//           one bit per CLK_DIV clocks. DESER_PREFETCH_EN adds a next-word
//           buffer for gapless playback.
// Revision: 1.0
// ============================================================================
module pdm_playback_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 50
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] memory_data_i,
    output logic                  word_request_o,
    output logic                  done_o,
    output logic                  audio_pwm_o,
    output logic                  audio_sd_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_end;
    logic                  word_end;

`ifdef DESER_PREFETCH_EN
    logic [DATA_WIDTH-1:0] next_buf;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  fetch_pending;
    logic                  reload;
`endif

    assign bit_end  = (div_cnt == DIV_LAST);
    assign word_end = bit_end && (bit_cnt == BIT_LAST);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        word_request_o = 1'b0;
        done_o         = 1'b0;
`ifdef DESER_PREFETCH_EN
        reload         = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enable_i) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                word_request_o = 1'b1;
                next_state     = enable_i ? LOAD : IDLE;
            end
            LOAD: begin
                next_state = enable_i ? SHIFT : IDLE;
            end
            SHIFT: begin
                done_o = word_end;
`ifdef DESER_PREFETCH_EN
                // Fetch the following word while the current one plays out.
                word_request_o = enable_i && (div_cnt == '0) && (bit_cnt == '0);
`endif
                if (!enable_i) begin
                    next_state = IDLE;
                end else if (word_end) begin
`ifdef DESER_PREFETCH_EN
                    reload = 1'b1;
`else
                    next_state = REQ;
`endif
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign audio_pwm_o = (state == SHIFT) && shift_reg[DATA_WIDTH-1];
    assign audio_sd_o  = (state != IDLE);

`ifdef DESER_PREFETCH_EN
    // Bypass covers a word that ends on the same cycle its successor arrives.
    assign next_word = fetch_pending ? memory_data_i : next_buf;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pending <= 1'b0;
            next_buf      <= '0;
        end else begin
            fetch_pending <= (state == SHIFT) && word_request_o;
            if (state == IDLE) begin
                next_buf <= '0;
            end else if (fetch_pending) begin
                next_buf <= memory_data_i;
            end
        end
    end
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shift_reg <= memory_data_i;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
`ifdef DESER_PREFETCH_EN
                        if (reload) begin
                            shift_reg <= next_word;
                            bit_cnt   <= '0;
                        end else begin
                            shift_reg <= shift_reg << 1;
                            bit_cnt   <= bit_cnt + BIT_ONE;
                        end
`else
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + BIT_ONE;
`endif
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    shift_reg <= '0;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
